operand_fetch: RTL and testbench

- Read-side sequencer for the 8-bit register file.
- Accepts a request naming two source registers and drives the register file's single combinational read port once per cycle.
- Captures both operands and holds them valid for the execute stage until acknowledged.
- Sits between decode (requester) and ALU (consumer); the register file's write port belongs to writeback and is not driven here.

---
 rtl/angstrom_pkg.sv | 14 +
 rtl/operand_fetch.sv | 109 ++++++++++
 tb/tb_operand_fetch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/angstrom_pkg.sv
// rtl/angstrom_pkg.sv - shared widths and operand fetch state encoding
package angstrom_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        HOLD = 2'd3
    } opf_state_t;

endpackage

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - two-operand register file read sequencer (optional OPF_WB_BYPASS_EN)
module operand_fetch
    import angstrom_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] rs_a_i,
    input  logic [ADDR_W-1:0] rs_b_i,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    input  logic              wb_wen_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic              valid_o,
    input  logic              ack_i
);

    opf_state_t        state, state_nxt;
    logic [ADDR_W-1:0] idx_a, idx_b;
    logic [DATA_W-1:0] cap_data;
    logic              same_idx;

    assign same_idx = (idx_a == idx_b);
    assign ready_o  = (state == IDLE);
    assign valid_o  = (state == HOLD);

`ifdef OPF_WB_BYPASS_EN
    // A write landing on the register being read this cycle wins over the stale array value
    assign cap_data = (wb_wen_i && (wb_addr_i == rf_raddr_o)) ? wb_data_i : rf_rdata_i;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_wen_i, wb_addr_i, wb_data_i};
    assign cap_data  = rf_rdata_i;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and read address decode; the read port idles at address 0
    always_comb begin
        state_nxt  = state;
        rf_raddr_o = '0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_nxt = RD_A;
                end
            end
            RD_A: begin
                rf_raddr_o = idx_a;
                state_nxt  = same_idx ? HOLD : RD_B;
            end
            RD_B: begin
                rf_raddr_o = idx_b;
                state_nxt  = HOLD;
            end
            HOLD: begin
                if (ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch source indices when a request is accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_a <= '0;
            idx_b <= '0;
        end else if ((state == IDLE) && req_i) begin
            idx_a <= rs_a_i;
            idx_b <= rs_b_i;
        end
    end

    // Operand capture; equal indices fill both operands from the single RD_A read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_a_o <= '0;
            op_b_o <= '0;
        end else begin
            case (state)
                RD_A: begin
                    op_a_o <= cap_data;
                    if (same_idx) begin
                        op_b_o <= cap_data;
                    end
                end
                RD_B:    op_b_o <= cap_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req_i;
    logic       ready_o;
    logic [2:0] rs_a_i, rs_b_i;
    logic [2:0] rf_raddr_o;
    logic [7:0] rf_rdata_i;
    logic       wb_wen_i;
    logic [2:0] wb_addr_i;
    logic [7:0] wb_data_i;
    logic [7:0] op_a_o, op_b_o;
    logic       valid_o;
    logic       ack_i;

    logic [7:0]  rf [8];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    operand_fetch dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .ready_o    (ready_o),
        .rs_a_i     (rs_a_i),
        .rs_b_i     (rs_b_i),
        .rf_raddr_o (rf_raddr_o),
        .rf_rdata_i (rf_rdata_i),
        .wb_wen_i   (wb_wen_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .op_a_o     (op_a_o),
        .op_b_o     (op_b_o),
        .valid_o    (valid_o),
        .ack_i      (ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Register file model: writeback port writes at the edge, read is combinational
    always @(posedge clk_i) begin
        if (wb_wen_i) rf[wb_addr_i] <= wb_data_i;
    end
    assign rf_rdata_i = rf[rf_raddr_o];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each rising valid_o must match the oldest outstanding expectation
    initial begin
        logic prev_valid;
        logic [15:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk_i);
            if (valid_o === 1'b1 && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("op_a", int'(op_a_o), int'(e[15:8]));
                    check("op_b", int'(op_b_o), int'(e[7:0]));
                end
            end
            prev_valid = (valid_o === 1'b1);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wb_wen_i  = 1'b1;
        wb_addr_i = a;
        wb_data_i = d;
        @(negedge clk_i);
        wb_wen_i  = 1'b0;
    endtask

    // Issue a request at a negedge; count edges (accept edge included) until valid_o
    task automatic fetch(input logic [2:0] a, input logic [2:0] b,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input int exp_edges, input bit byp);
        int edges;
        req_i  = 1'b1;
        rs_a_i = a;
        rs_b_i = b;
        exp_q.push_back({ea, eb});
        edges = 0;
        do begin
            @(posedge clk_i);
            edges++;
            @(negedge clk_i);
            if (edges == 1) begin
                req_i = 1'b0;
                check("raddr_a", int'(rf_raddr_o), int'(a));
                if (byp) begin
                    wb_wen_i  = 1'b1;
                    wb_addr_i = a;
                    wb_data_i = 8'hEE;
                end
            end
            if (edges == 2) begin
                wb_wen_i = 1'b0;
                if (!valid_o) check("raddr_b", int'(rf_raddr_o), int'(b));
            end
        end while (valid_o !== 1'b1 && edges < 8);
        check("latency", edges, exp_edges);
        check("raddr_hold", int'(rf_raddr_o), 0);
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        check("ready_after_ack", int'(ready_o), 1);
        check("valid_after_ack", int'(valid_o), 0);
    endtask

    initial begin
        logic [7:0] init_v [8];
        logic [7:0] bp_a;
        init_v = '{8'h00, 8'h55, 8'h3C, 8'h10, 8'h77, 8'hA1, 8'hC3, 8'h5A};
        rst_ni = 1'b0; req_i = 1'b0; ack_i = 1'b0;
        rs_a_i = '0; rs_b_i = '0;
        wb_wen_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_valid", int'(valid_o), 0);
        check("rst_op_a", int'(op_a_o), 0);
        check("rst_op_b", int'(op_b_o), 0);
        check("rst_raddr", int'(rf_raddr_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_ready", int'(ready_o), 1);
        for (int i = 0; i < 8; i++) wr(3'(i), init_v[i]);

        // Basic fetch, then reset mid-stream while holding
        fetch(3'd2, 3'd5, 8'h3C, 8'hA1, 3, 1'b0);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        check("midrst_valid", int'(valid_o), 0);
        check("midrst_op_a", int'(op_a_o), 0);
        check("midrst_op_b", int'(op_b_o), 0);
        @(negedge clk_i);
        check("midrst_ready", int'(ready_o), 1);

        // Equal indices skip RD_B, then backpressure
        fetch(3'd4, 3'd4, 8'h77, 8'h77, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            req_i     = i[0];
            rs_a_i    = 3'(i);
            rs_b_i    = 3'(7 - i);
            wb_wen_i  = 1'b1;
            wb_addr_i = 3'd0;
            wb_data_i = 8'(i * 37 + 1);
            @(negedge clk_i);
            check("bp_op_a", int'(op_a_o), 8'h77);
            check("bp_op_b", int'(op_b_o), 8'h77);
            check("bp_ready", int'(ready_o), 0);
            check("bp_valid", int'(valid_o), 1);
        end
        req_i = 1'b0;
        wb_wen_i = 1'b0;
        do_ack();
        check("idle_keep_a", int'(op_a_o), 8'h77);
        @(negedge clk_i);
        check("idle_no_fetch", int'(valid_o), 0);

        // Writeback to r3 during the RD_A cycle
`ifdef OPF_WB_BYPASS_EN
        bp_a = 8'hEE;
`else
        bp_a = 8'h10;
`endif
        fetch(3'd3, 3'd1, bp_a, 8'h55, 3, 1'b1);
        do_ack();

        // Abort in RD_B
        req_i = 1'b1; rs_a_i = 3'd6; rs_b_i = 3'd7;
        exp_q.push_back({8'hC3, 8'h5A});
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        check("abort_raddr_b", int'(rf_raddr_o), 7);
        rst_ni = 1'b0;
        #1;
        check("abort_op_a", int'(op_a_o), 0);
        check("abort_op_b", int'(op_b_o), 0);
        check("abort_valid", int'(valid_o), 0);
        check("abort_raddr", int'(rf_raddr_o), 0);
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("abort_ready", int'(ready_o), 1);
        fetch(3'd6, 3'd7, 8'hC3, 8'h5A, 3, 1'b0);
        do_ack();

        repeat (2) @(negedge clk_i);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
